// File: rtl/fnd_scan_decoder.sv
// Recovers BCD frames from a multiplexed 4-digit 7-segment scan (active-low com and segments).
// A digit is captured SETTLE_CYC+1 edges after its pair reaches the input stage edge; the scan source has no backpressure.
module fnd_scan_decoder #(
    parameter int SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_data,
    output logic [15:0] frame_bcd,
    output logic [3:0]  frame_dp,
    output logic        frame_err,
    output logic        frame_valid,
    output logic        com_err
);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        HOLD   = 2'd1,
        BLANK  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYC - 1);

    state_t          state_q;
    logic [3:0]      com_q;
    logic [3:0]      com_prev_q;
    logic [7:0]      data_q;
    logic [7:0]      data_prev_q;
    logic [7:0]      cnt_q;
    logic [3:0]      seen_q;
    logic [3:0][3:0] buf_bcd_q;
    logic [3:0]      buf_dp_q;
    logic [3:0]      buf_err_q;

    logic            stable;
    logic            com_legal;
    logic [1:0]      dig_idx;
    logic [3:0]      dig_bcd;
    logic            dig_err;
    logic [3:0]      seen_d;
    logic [3:0][3:0] merged_bcd_d;
    logic [3:0]      merged_dp_d;
    logic [3:0]      merged_err_d;

    assign stable = (com_q == com_prev_q) && (data_q == data_prev_q);

    always_comb begin
        com_legal = 1'b1;
        dig_idx   = 2'd0;
        case (com_q)
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: com_legal = 1'b0;
        endcase
    end

    always_comb begin
        dig_bcd = 4'hF;
        dig_err = 1'b0;
        case (data_q[6:0])
            7'h40:   dig_bcd = 4'd0;
            7'h79:   dig_bcd = 4'd1;
            7'h24:   dig_bcd = 4'd2;
            7'h30:   dig_bcd = 4'd3;
            7'h19:   dig_bcd = 4'd4;
            7'h12:   dig_bcd = 4'd5;
            7'h02:   dig_bcd = 4'd6;
            7'h78:   dig_bcd = 4'd7;
            7'h00:   dig_bcd = 4'd8;
            7'h10:   dig_bcd = 4'd9;
            default: dig_err = 1'b1;
        endcase
    end

    // Working buffer with the digit being captured substituted, so the completing digit lands in the frame.
    always_comb begin
        seen_d                = seen_q | (4'b0001 << dig_idx);
        merged_bcd_d          = buf_bcd_q;
        merged_dp_d           = buf_dp_q;
        merged_err_d          = buf_err_q;
        merged_bcd_d[dig_idx] = dig_bcd;
        merged_dp_d[dig_idx]  = ~data_q[7];
        merged_err_d[dig_idx] = dig_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SETTLE;
            com_q       <= 4'b1111;
            com_prev_q  <= 4'b1111;
            data_q      <= 8'hFF;
            data_prev_q <= 8'hFF;
            cnt_q       <= 8'd0;
            seen_q      <= 4'd0;
            buf_bcd_q   <= '0;
            buf_dp_q    <= 4'd0;
            buf_err_q   <= 4'd0;
            frame_bcd   <= 16'h0000;
            frame_dp    <= 4'h0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
            com_err     <= 1'b0;
        end else begin
            com_q       <= fnd_com;
            data_q      <= fnd_data;
            com_prev_q  <= com_q;
            data_prev_q <= data_q;
            frame_valid <= 1'b0;
            com_err     <= 1'b0;
            case (state_q)
                SETTLE: begin
                    if (!stable) begin
                        cnt_q <= 8'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= 8'd0;
                        if (com_legal) begin
                            state_q <= HOLD;
                            if (seen_d == 4'b1111) begin
                                frame_bcd   <= merged_bcd_d;
                                frame_dp    <= merged_dp_d;
                                frame_err   <= |merged_err_d;
                                frame_valid <= 1'b1;
                                seen_q      <= 4'd0;
                                buf_err_q   <= 4'd0;
                            end else begin
                                seen_q    <= seen_d;
                                buf_bcd_q <= merged_bcd_d;
                                buf_dp_q  <= merged_dp_d;
                                buf_err_q <= merged_err_d;
                            end
                        end else if (com_q == 4'b1111) begin
                            state_q <= BLANK;
                        end else begin
                            com_err <= 1'b1;
                            state_q <= HOLD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                HOLD, BLANK: begin
                    if (!stable) begin
                        state_q <= SETTLE;
                        cnt_q   <= 8'd0;
                    end
                end
                default: begin
                    state_q <= SETTLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/fnd_scan_decoder.md
FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 4, meaning the number of consecutive cycles a registered (fnd_com, fnd_data) pair must be unchanged before it is captured; legal range is 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port fnd_com, input, 4 bits: digit select, active-low one-hot; 4'b1110 selects digit0 (ones), 4'b1101 digit1, 4'b1011 digit2, 4'b0111 digit3.
REQ-005 The block SHALL have port fnd_data, input, 8 bits: segments, active-low; bit0 is a through bit6 is g, and bit7 is dp.
REQ-006 The block SHALL have port frame_bcd, output, 16 bits: the last complete frame as {digit3, digit2, digit1, digit0}, 4-bit BCD each.
REQ-007 The block SHALL have port frame_dp, output, 4 bits: the per-digit decimal point of the last frame, active-high; bit n corresponds to digit n.
REQ-008 The block SHALL have port frame_err, output, 1 bit: high when at least one digit of the last frame had an undecodable segment pattern.
REQ-009 The block SHALL have port frame_valid, output, 1 bit: a single-cycle pulse marking an update of frame_bcd, frame_dp and frame_err.
REQ-010 The block SHALL have port com_err, output, 1 bit: a single-cycle pulse marking a settled, illegal fnd_com code.

Function
REQ-011 The block SHALL register fnd_com and fnd_data into an input stage every cycle; all further logic SHALL use only the registered values.
REQ-012 The block SHALL implement a state machine with three states: SETTLE, HOLD and BLANK.
REQ-013 While in SETTLE, the block SHALL count cycles in which the registered pair equals its value from the previous cycle, and SHALL clear that count on any difference.
REQ-014 When the stable count reaches SETTLE_CYC, the block SHALL act once on the registered pair as follows.
- Legal one-hot fnd_com: capture the digit, go to HOLD.
- fnd_com = 4'b1111: no capture, no error, go to BLANK.
- Any other fnd_com: pulse com_err for one cycle, no capture, go to HOLD.
REQ-015 In HOLD or BLANK, the block SHALL return to SETTLE with the count cleared on the first cycle in which the registered pair changes; a long dwell SHALL produce exactly one capture.
REQ-016 The block SHALL decode fnd_data[6:0] as follows: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
- Any other pattern: store 4'hF and set that digit's error bit.
REQ-017 The dp bit of a captured digit SHALL be stored as ~fnd_data[7].
REQ-018 Capture SHALL write the digit's value, dp bit and error bit into a working buffer and set that digit's bit in a 4-bit seen-mask.
- A repeat capture of an already-seen digit SHALL overwrite that digit's entry (latest value wins).
REQ-019 On the same clock edge at which the seen-mask would become 4'b1111, the block SHALL:
- load frame_bcd, frame_dp, and frame_err (OR of the four error bits) from the working buffer including the digit being captured;
- assert frame_valid for that one cycle;
- clear the seen-mask and error bits.
REQ-020 Latency SHALL be exactly SETTLE_CYC+1 rising edges from the first edge at which the final digit's input pair is present to the edge on which frame_valid rises.
REQ-021 Digit order within a frame SHALL be irrelevant; only coverage of all four positions matters.
REQ-022 frame_bcd, frame_dp and frame_err SHALL hold their values between frame_valid pulses.

Reset
REQ-023 While rst = 0, the block SHALL asynchronously set the following:
- frame_bcd = 16'h0000, frame_dp = 4'h0, frame_err = 0, frame_valid = 0, com_err = 0;
- seen-mask = 0, stable count = 0, state = SETTLE;
- input stage = {4'b1111, 8'hFF}.
REQ-024 After rst is released, the first capture SHALL require a full SETTLE_CYC stable window.
REQ-025 A reset asserted mid-frame SHALL discard the partial frame, and no frame_valid SHALL follow from it.

Verification (SETTLE_CYC = 4)
REQ-026 The bench SHALL drive com/data pairs 1110/C0, 1101/F9, 1011/A4, 0111/B0, each for 8 cycles, and SHALL check:
- exactly one frame_valid pulse;
- frame_bcd = 16'h3210, frame_dp = 0, frame_err = 0;
- frame_valid rising 5 edges after 0111/B0 is first applied.
REQ-027 The bench SHALL hold digit1 for only 3 cycles inside a scan, then complete the other three digits, and SHALL check that no frame_valid occurs until digit1 is later held for 4 or more cycles.
REQ-028 The bench SHALL present com = 4'b1100 for 6 cycles and SHALL check:
- com_err pulses exactly once, 5 edges after it is applied;
- the seen-mask is unchanged.
REQ-029 The bench SHALL scan 0=C0, 1=F9, 2=FF (invalid), 3=10 (digit 9 with dp on) and SHALL check that frame_bcd = 16'h9F10, frame_dp = 4'b1000 and frame_err = 1.
REQ-030 The bench SHALL insert a 4'b1111 blank dwell between every digit dwell and SHALL check that frames are unaffected and no com_err occurs.
REQ-031 The bench SHALL assert rst after three digits have been captured, then release it and scan one digit only, and SHALL check:
- all outputs read zero;
- no frame_valid occurs.
